alu_ctrl: RTL

Sequencing controller for the 8-bit ALU datapath. It drives the 9-bit accumulator A, the multiplier/quotient register Q, the operand register M and the shared adder/subtractor. It runs add, subtract, Booth radix-2 multiply and non-restoring divide as multi-cycle micro-sequences started by a single `start` pulse. All register controls it produces use the shift-register encoding: 00 hold, 01 shift right arithmetic, 10 shift left, 11 parallel load.

---
 rtl/alu_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
// Sequencing controller for the 8-bit ALU datapath (9-bit accumulator A,
// multiplier/quotient register Q with Booth bit Q[-1], operand register M and
// a shared adder/subtractor). A single start pulse runs add, subtract, Booth
// radix-2 multiply or non-restoring divide as a multi-cycle micro-sequence.
//
// Register control encoding (a_sel, q_sel):
//    00 hold, 01 shift right arithmetic, 10 shift left, 11 parallel load.
//
// Ports
//    clk        in   clock, rising edge
//    rst_b      in   synchronous reset, active-high
//    start      in   operation request, sampled only in IDLE
//    op         in   00 add, 01 sub, 10 mul, 11 div (latched on start)
//    q0         in   Q[0]
//    q_m1       in   Q[-1]
//    a_sign     in   A[N]
//    m_zero     in   M == 0
//    in_sel     out  input bus mux: 0 operand X, 1 operand Y
//    a_src      out  A load source: 00 zero, 01 input bus, 10 adder
//    a_sel      out  A register control
//    q_sel      out  Q register control
//    m_load     out  M <- input bus
//    alu_sub    out  adder computes A-M when 1, A+M when 0
//    qm1_clr    out  Q[-1] <- 0
//    qm1_shift  out  Q[-1] <- Q[0]
//    q0_wr      out  Q[0] <- q0_val
//    q0_val     out  bit written to Q[0]
//    busy       out  high in every state except IDLE
//    done       out  one-cycle pulse in FIN
//    err        out  divide-by-zero flag, held until the next accepted start
// -----------------------------------------------------------------------------
module alu_ctrl #(
   parameter int N  = 8,
   parameter int CW = 4
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       start,
   input  logic [1:0] op,
   input  logic       q0,
   input  logic       q_m1,
   input  logic       a_sign,
   input  logic       m_zero,
   output logic       in_sel,
   output logic [1:0] a_src,
   output logic [1:0] a_sel,
   output logic [1:0] q_sel,
   output logic       m_load,
   output logic       alu_sub,
   output logic       qm1_clr,
   output logic       qm1_shift,
   output logic       q0_wr,
   output logic       q0_val,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [1:0] SR_HOLD = 2'b00;
   localparam logic [1:0] SR_ASR  = 2'b01;
   localparam logic [1:0] SR_SHL  = 2'b10;
   localparam logic [1:0] SR_LOAD = 2'b11;

   localparam logic [1:0] SRC_ZERO = 2'b00;
   localparam logic [1:0] SRC_BUS  = 2'b01;
   localparam logic [1:0] SRC_ADD  = 2'b10;

   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [3:0] {
      IDLE, LD1, LD2, ADD, MTEST, MSHIFT, DSHIFT, DOP, DSETQ, DCORR, FIN
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    op_q, op_d;
   logic          err_q, err_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      err_d     = err_q;
      in_sel    = 1'b0;
      a_src     = SRC_ZERO;
      a_sel     = SR_HOLD;
      q_sel     = SR_HOLD;
      m_load    = 1'b0;
      alu_sub   = 1'b0;
      qm1_clr   = 1'b0;
      qm1_shift = 1'b0;
      q0_wr     = 1'b0;
      q0_val    = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LD1;
               op_d    = op;
               err_d   = 1'b0;
            end
         end
         LD1: begin
            // add/sub: A <- X ; mul/div: M <- X
            if (!op_q[1]) begin
               a_sel = SR_LOAD;
               a_src = SRC_BUS;
            end else begin
               m_load = 1'b1;
            end
            state_d = LD2;
         end
         LD2: begin
            in_sel = 1'b1;
            if (!op_q[1]) begin
               m_load  = 1'b1;
               state_d = ADD;
            end else begin
               q_sel   = SR_LOAD;
               a_sel   = SR_LOAD;
               a_src   = SRC_ZERO;
               qm1_clr = 1'b1;
               cnt_d   = '0;
               // m_zero already reflects the divisor loaded in LD1
               if (op_q[0] && m_zero) begin
                  err_d   = 1'b1;
                  state_d = FIN;
               end else begin
                  state_d = op_q[0] ? DSHIFT : MTEST;
               end
            end
         end
         ADD: begin
            a_sel   = SR_LOAD;
            a_src   = SRC_ADD;
            alu_sub = op_q[0];
            state_d = FIN;
         end
         MTEST: begin
            // Booth pair {Q[0],Q[-1]}: 01 add M, 10 subtract M, else hold
            if (q0 != q_m1) begin
               a_sel   = SR_LOAD;
               a_src   = SRC_ADD;
               alu_sub = q0;
            end
            state_d = MSHIFT;
         end
         MSHIFT: begin
            a_sel     = SR_ASR;
            q_sel     = SR_ASR;
            qm1_shift = 1'b1;
            cnt_d     = cnt_q + CW'(1);
            state_d   = (cnt_q == CNT_LAST) ? FIN : MTEST;
         end
         DSHIFT: begin
            a_sel   = SR_SHL;
            q_sel   = SR_SHL;
            state_d = DOP;
         end
         DOP: begin
            // non-restoring step: subtract when A is non-negative, else add
            a_sel   = SR_LOAD;
            a_src   = SRC_ADD;
            alu_sub = ~a_sign;
            state_d = DSETQ;
         end
         DSETQ: begin
            q0_wr   = 1'b1;
            q0_val  = ~a_sign;
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CNT_LAST) ? DCORR : DSHIFT;
         end
         DCORR: begin
            // negative remainder is restored by one final add
            if (a_sign) begin
               a_sel = SR_LOAD;
               a_src = SRC_ADD;
            end
            state_d = FIN;
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign err  = err_q;

endmodule
